row_padding: RTL and testbench

- Downstream neighbour of the 2-ppc column-padding stage.
- Takes column-padded lines (2 pixels per beat, tuser[0]=SOF, tlast=EOL) and adds 2 replicated rows at the top and 2 at the bottom of each frame. Output height is img_rows+4.
- Lines pass straight through and are also written into a single line RAM. The first and last lines of each frame are replayed from that RAM while input is stalled.
- Output goes to the window/line-buffer stage over AXI-stream.

---
 rtl/row_padding_pkg.sv | 19 +
 rtl/line_ram.sv | 27 ++
 rtl/row_padding.sv | 266 ++++++++++++++++++++++++++
 tb/tb_row_padding.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/row_padding_pkg.sv
// Shared types and constants for the row-padding stage.
package row_padding_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_PASS,
    S_REPLAY
  } state_e;

  localparam int unsigned PPC      = 2;
  localparam int unsigned PAD_ROWS = 2;

  // Rows per frame as used by the datapath; zero is treated as one.
  function automatic logic [31:0] eff_rows(input logic [31:0] rows);
    return (rows == 32'd0) ? 32'd1 : rows;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM with a registered (1-cycle) read port.
module line_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 1024,
  localparam int unsigned Aw   = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/row_padding.sv
// Adds PAD_ROWS replicated rows above and below each frame by replaying the first
// and last lines from a line RAM while the input is stalled.
module row_padding
  import row_padding_pkg::*;
#(
  parameter int unsigned TUSER_WIDTH = 5,
  parameter int unsigned TDEST_WIDTH = 2,
  parameter int unsigned TDATA_WIDTH = 8,
  parameter int unsigned MAX_BEATS   = 1024,
  parameter int unsigned ROW_WIDTH   = 12
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ROW_WIDTH-1:0]       img_rows,
  input  logic [TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [TDEST_WIDTH-1:0]     s_axis_tdest,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [PPC*TDATA_WIDTH-1:0] s_axis_tdata,
  output logic [TUSER_WIDTH-1:0]     m_axis_tuser,
  output logic [TDEST_WIDTH-1:0]     m_axis_tdest,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic [PPC*TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                       err_pulse
);

  localparam int unsigned DW = PPC * TDATA_WIDTH;
  localparam int unsigned AW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned LW = $clog2(MAX_BEATS + 1);

  typedef struct packed {
    logic [DW-1:0]          data;
    logic                   last;
    logic [TUSER_WIDTH-1:0] user;
    logic [TDEST_WIDTH-1:0] dest;
  } beat_t;

  state_e                 state_q, state_d;
  logic [ROW_WIDTH-1:0]   rows_q, rows_d;
  logic [ROW_WIDTH-1:0]   row_q, row_d;
  logic [TUSER_WIDTH-2:0] user_hi_q, user_hi_d;
  logic [TDEST_WIDTH-1:0] dest_q, dest_d;
  logic [LW-1:0]          wr_ptr_q, wr_ptr_d;
  logic                   ovf_q, ovf_d;
  logic [LW-1:0]          line_len_q, line_len_d;
  logic [2:0]             rep_tgt_q, rep_tgt_d;
  logic                   bottom_q, bottom_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [2:0]             iss_rep_q, iss_rep_d;
  logic [2:0]             push_rep_q, push_rep_d;
  logic                   rd_pend_q, rd_pend_d;
  logic                   rd_last_q, rd_last_d;
  logic                   err_q, err_d;
  beat_t                  skid_q [2];
  beat_t                  skid_d [2];
  logic [1:0]             cnt_q, cnt_d;

  logic                 s_ready, s_hs, sof, take, m_pop, push, issue, iss_last;
  beat_t                push_beat;
  logic [LW-1:0]        wr_base;
  logic                 ovf_cur, ram_we;
  logic [ROW_WIDTH-1:0] row_cur, rows_cur;
  logic [DW-1:0]        ram_rdata;

  assign s_ready       = ((state_q == S_WAIT_SOF) || (state_q == S_PASS)) && (cnt_q != 2'd2);
  assign s_axis_tready = s_ready;
  assign s_hs          = s_axis_tvalid & s_ready;
  assign sof           = s_axis_tuser[0];
  // Non-SOF beats seen while waiting for a frame are dropped.
  assign take          = s_hs && (sof || (state_q == S_PASS));
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign m_pop         = m_axis_tvalid & m_axis_tready;
  assign push          = take | rd_pend_q;

  assign m_axis_tdata  = skid_q[0].data;
  assign m_axis_tlast  = skid_q[0].last;
  assign m_axis_tuser  = skid_q[0].user;
  assign m_axis_tdest  = skid_q[0].dest;
  assign err_pulse     = err_q;

  always_comb begin
    push_beat = '0;
    if (rd_pend_q) begin
      push_beat.data = ram_rdata;
      push_beat.last = rd_last_q;
      push_beat.user = {user_hi_q, 1'b0};
      push_beat.dest = dest_q;
    end else begin
      push_beat.data = s_axis_tdata;
      push_beat.last = s_axis_tlast;
      push_beat.user = sof ? {s_axis_tuser[TUSER_WIDTH-1:1], 1'b1} : {user_hi_q, 1'b0};
      push_beat.dest = sof ? s_axis_tdest : dest_q;
    end
  end

  // Skid: entry 0 drives the bus; a pop shifts entry 1 down before the push lands.
  always_comb begin
    skid_d = skid_q;
    cnt_d  = cnt_q;
    if (m_pop) begin
      skid_d[0] = skid_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (push) begin
      if (cnt_d == 2'd0) begin
        skid_d[0] = push_beat;
      end else begin
        skid_d[1] = push_beat;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  // A replay read is only issued when its data is guaranteed a skid slot next cycle.
  assign iss_last = (LW'(rd_ptr_q) + LW'(1)) == line_len_q;
  assign issue    = (state_q == S_REPLAY) && (iss_rep_q != rep_tgt_q) && (cnt_d != 2'd2);

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    row_d      = row_q;
    user_hi_d  = user_hi_q;
    dest_d     = dest_q;
    wr_ptr_d   = wr_ptr_q;
    ovf_d      = ovf_q;
    line_len_d = line_len_q;
    rep_tgt_d  = rep_tgt_q;
    bottom_d   = bottom_q;
    rd_ptr_d   = rd_ptr_q;
    iss_rep_d  = iss_rep_q;
    push_rep_d = push_rep_q;
    rd_pend_d  = issue;
    rd_last_d  = issue & iss_last;
    err_d      = 1'b0;
    wr_base    = wr_ptr_q;
    ovf_cur    = ovf_q;
    row_cur    = row_q;
    rows_cur   = rows_q;
    ram_we     = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_WAIT_SOF;

      S_WAIT_SOF, S_PASS: begin
        if (take) begin
          if (sof) begin
            err_d     = (state_q == S_PASS);
            rows_cur  = ROW_WIDTH'(eff_rows(32'(img_rows)));
            rows_d    = rows_cur;
            user_hi_d = s_axis_tuser[TUSER_WIDTH-1:1];
            dest_d    = s_axis_tdest;
            row_cur   = '0;
            row_d     = '0;
            wr_base   = '0;
            ovf_cur   = 1'b0;
            state_d   = S_PASS;
          end
          ram_we   = (wr_base != LW'(MAX_BEATS));
          wr_ptr_d = ram_we ? wr_base + LW'(1) : wr_base;
          ovf_d    = ovf_cur;
          if (!ram_we && !ovf_cur) begin
            err_d = 1'b1;
            ovf_d = 1'b1;
          end
          if (s_axis_tlast) begin
            line_len_d = wr_ptr_d;
            wr_ptr_d   = '0;
            ovf_d      = 1'b0;
            if ((row_cur == '0) || (row_cur == rows_cur - ROW_WIDTH'(1))) begin
              state_d    = S_REPLAY;
              bottom_d   = (row_cur == rows_cur - ROW_WIDTH'(1));
              rep_tgt_d  = (rows_cur == ROW_WIDTH'(1)) ? 3'(2 * PAD_ROWS) : 3'(PAD_ROWS);
              rd_ptr_d   = '0;
              iss_rep_d  = '0;
              push_rep_d = '0;
            end else begin
              row_d = row_cur + ROW_WIDTH'(1);
            end
          end
        end
      end

      S_REPLAY: begin
        if (issue) begin
          rd_ptr_d  = iss_last ? '0 : rd_ptr_q + AW'(1);
          iss_rep_d = iss_last ? iss_rep_q + 3'd1 : iss_rep_q;
        end
        // Leave only once the final replayed beat has entered the skid.
        if (rd_pend_q && rd_last_q) begin
          push_rep_d = push_rep_q + 3'd1;
          if (push_rep_d == rep_tgt_q) begin
            if (bottom_q) begin
              state_d = S_WAIT_SOF;
            end else begin
              row_d   = row_q + ROW_WIDTH'(1);
              state_d = S_PASS;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      row_q      <= '0;
      user_hi_q  <= '0;
      dest_q     <= '0;
      wr_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      line_len_q <= '0;
      rep_tgt_q  <= '0;
      bottom_q   <= 1'b0;
      rd_ptr_q   <= '0;
      iss_rep_q  <= '0;
      push_rep_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      row_q      <= row_d;
      user_hi_q  <= user_hi_d;
      dest_q     <= dest_d;
      wr_ptr_q   <= wr_ptr_d;
      ovf_q      <= ovf_d;
      line_len_q <= line_len_d;
      rep_tgt_q  <= rep_tgt_d;
      bottom_q   <= bottom_d;
      rd_ptr_q   <= rd_ptr_d;
      iss_rep_q  <= iss_rep_d;
      push_rep_q <= push_rep_d;
      rd_pend_q  <= rd_pend_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
      skid_q[0]  <= skid_d[0];
      skid_q[1]  <= skid_d[1];
      cnt_q      <= cnt_d;
    end
  end

  line_ram #(
    .Width (DW),
    .Depth (MAX_BEATS)
  ) u_line_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_base[AW-1:0]),
    .wdata_i (s_axis_tdata),
    .re_i    (issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_row_padding.sv
// Randomised bench for row_padding: a frame-level model predicts the output beat stream.
module tb_row_padding;

  localparam int MAXB = 8;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [4:0]  user;
    logic [1:0]  dest;
  } beat_t;

  typedef struct packed {
    beat_t       b;
    logic [11:0] rows;
  } in_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] img_rows;
  logic [4:0]  s_axis_tuser;
  logic [1:0]  s_axis_tdest;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [15:0] s_axis_tdata;
  logic [4:0]  m_axis_tuser;
  logic [1:0]  m_axis_tdest;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic [15:0] m_axis_tdata;
  logic        err_pulse;

  int    n_chk = 0, n_pass = 0;
  int    err_cnt = 0, exp_err = 0, out_cnt = 0;
  bit    rdy_rand = 0;
  bit    hold_v = 0;
  beat_t held;
  in_t   in_q [$];
  beat_t exp_q [$];

  row_padding #(
    .TUSER_WIDTH (5),
    .TDEST_WIDTH (2),
    .TDATA_WIDTH (8),
    .MAX_BEATS   (MAXB),
    .ROW_WIDTH   (12)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .img_rows      (img_rows),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tdest  (s_axis_tdest),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .err_pulse     (err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Frame model: every row passes through; row 0 is repeated twice after itself and the
  // last row twice after itself (both for a one-row frame). Replays hold at most MAXB beats.
  task automatic gen_frame(input int rows_cfg, input int len, input bit seq,
                           input int ab_row, input int ab_beat);
    int          n, rl;
    logic [3:0]  up;
    logic [1:0]  dst;
    logic [15:0] line [64];
    in_t         ib;
    beat_t       eb;
    n   = (rows_cfg == 0) ? 1 : rows_cfg;
    up  = 4'($urandom);
    dst = 2'($urandom);
    rl  = (len > MAXB) ? MAXB : len;
    for (int r = 0; r < n; r++) begin
      for (int b = 0; b < len; b++) begin
        if (r == ab_row && b == ab_beat) return;
        ib.b.data = seq ? 16'(r * 16 + b) : 16'($urandom);
        ib.b.last = (b == len - 1);
        ib.b.user = {4'($urandom), 1'b0};
        ib.b.dest = 2'($urandom);
        if (r == 0 && b == 0) begin
          ib.b.user = {up, 1'b1};
          ib.b.dest = dst;
        end
        ib.rows = 12'(rows_cfg);
        in_q.push_back(ib);
        line[b] = ib.b.data;
        eb.data = ib.b.data;
        eb.last = ib.b.last;
        eb.user = {up, ib.b.user[0]};
        eb.dest = dst;
        exp_q.push_back(eb);
      end
      if (len > MAXB) exp_err++;
      for (int k = 0; k < ((r == 0) ? 2 : 0) + ((r == n - 1) ? 2 : 0); k++) begin
        for (int b = 0; b < rl; b++) begin
          eb.data = line[b];
          eb.last = (b == rl - 1);
          eb.user = {up, 1'b0};
          eb.dest = dst;
          exp_q.push_back(eb);
        end
      end
    end
  endtask

  task automatic add_junk();
    in_t ib;
    ib.b.data = 16'($urandom);
    ib.b.last = 1'($urandom);
    ib.b.user = {4'($urandom), 1'b0};
    ib.b.dest = 2'($urandom);
    ib.rows   = 12'($urandom_range(0, 5));
    in_q.push_back(ib);
  endtask

  // Called aligned to posedge+1; returns aligned the same way.
  task automatic send_all();
    in_t ib;
    int  t;
    while (in_q.size() != 0) begin
      ib = in_q.pop_front();
      if ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      s_axis_tdata  = ib.b.data;
      s_axis_tlast  = ib.b.last;
      s_axis_tuser  = ib.b.user;
      s_axis_tdest  = ib.b.dest;
      img_rows      = ib.rows;
      s_axis_tvalid = 1'b1;
      t = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        t++;
        if (t > 5000) begin
          n_chk++;
          $display("FAIL send_timeout: s_axis_tready stayed 0, expected 1");
          $display("%0d/%0d checks passed", n_pass, n_chk);
          $fatal(1, "input stalled");
        end
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk(name, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    chk({name, "_err"}, err_cnt, exp_err);
  endtask

  always @(posedge clk) begin
    #1;
    m_axis_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    beat_t cur;
    cur = {m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_tdest};
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v) chk("hold", {m_axis_tvalid, cur}, {1'b1, held});
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", {m_axis_tvalid, cur}, 0);
        else chk("beat", cur, exp_q.pop_front());
        out_cnt++;
        hold_v = 0;
      end else if (m_axis_tvalid) begin
        hold_v = 1;
        held   = cur;
      end else begin
        hold_v = 0;
      end
      if (err_pulse) err_cnt++;
    end
  end

  initial begin
    int t;
    rst_n         = 1'b0;
    img_rows      = '0;
    s_axis_tuser  = '0;
    s_axis_tdest  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdest,
                          m_axis_tdata, s_axis_tready, err_pulse}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // img_rows=3, 4-beat lines, data=row*16+beat, tready=1
    gen_frame(3, 4, 1, -1, 0);
    chk("model_len_3x4", exp_q.size(), 28);
    chk("model_row1_first", exp_q[12].data, 16'h0010);
    chk("model_bot_replay", {exp_q[24].data, exp_q[27].last}, {16'h0020, 1'b1});
    chk("model_sof_bits", {exp_q[0].user[0], exp_q[4].user[0]}, 2'b10);
    send_all();
    wait_drain("frame_3x4");

    // Same frame under random backpressure
    rdy_rand = 1;
    gen_frame(3, 4, 1, -1, 0);
    send_all();
    wait_drain("frame_3x4_bp");

    // img_rows=1 and img_rows=0: five copies of the single line
    gen_frame(1, 3, 0, -1, 0);
    chk("model_len_1x3", exp_q.size(), 15);
    send_all();
    wait_drain("frame_1x3");
    chk("ready_wait_sof", s_axis_tready, 1'b1);
    gen_frame(0, 3, 0, -1, 0);
    chk("model_len_0x3", exp_q.size(), 15);
    send_all();
    wait_drain("frame_0x3");

    // SOF at beat 2 of row 1 abandons the frame
    gen_frame(4, 4, 0, 1, 2);
    exp_err++;
    gen_frame(2, 5, 0, -1, 0);
    send_all();
    wait_drain("sof_abort");

    // 10-beat lines overflow the 8-beat RAM
    gen_frame(2, 10, 0, -1, 0);
    chk("model_len_ovf", exp_q.size(), 52);
    send_all();
    wait_drain("overflow");

    // Reset while the top replay is streaming
    rdy_rand = 0;
    gen_frame(3, 4, 0, 1, 0);
    send_all();
    t = 0;
    while (out_cnt < 0 + 6 + (out_cnt - out_cnt) && t < 0) t++;
    begin
      int base = out_cnt;
      t = 0;
      while (out_cnt - base < 6 && t < 1000) begin
        @(posedge clk);
        t++;
      end
      chk("reach_replay", (out_cnt - base >= 6) ? 1 : 0, 1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_replay", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdest,
                             m_axis_tdata, s_axis_tready, err_pulse}, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    add_junk();
    gen_frame(3, 4, 1, -1, 0);
    send_all();
    wait_drain("after_reset");

    // Random frames with stray non-SOF beats between them
    for (int f = 0; f < 12; f++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) add_junk();
      gen_frame($urandom_range(0, 5), $urandom_range(1, MAXB), 0, -1, 0);
      send_all();
      wait_drain("random_frame");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
